fifo_wr_sdram: RTL
==================

Name: fifo_wr_sdram

Overview:
- Write-direction bridge from the QSPI slave to the SDRAM controller write port.
- The QSPI side pushes 16-bit words into an async FIFO in qspi_clk.
- A write request, given as a level on qspi_wr_req, is synchronized into sdram_clk. There an FSM issues one address handshake, then drains WR_BL words from the FIFO into the controller data handshake.
- Byte order is swapped on the way into SDRAM. This is the inverse of the read path, so a written word reads back identical.

Parameters:
- WR_BL, 3'd2: words per write burst (1..7).
- FIFO_ASIZE, 10: async FIFO address size passed to asyn_fifo_top.

Ports:
- sdram_clk  in  1  SDRAM controller clock, 133 MHz; FIFO read side and FSM.
- rst_n  in  1  async active-low reset, both FIFO sides and all sdram_clk flops.
- qspi_clk  in  1  QSPI clock, <50 MHz; FIFO write clock.
- qspi_wr_addr  in  24  word address; bits [21:0] used; stable while qspi_wr_req high.
- qspi_wr_req  in  1  level request from qspi_clk domain; rising edge starts one burst.
- qspi_wr_busy  out  1  high whenever FSM not in S_WR_IDLE (sdram_clk domain).
- fifo_wen  in  1  qspi_clk push strobe.
- fifo_wdata  in  16  push data.
- fifo_wfull  out  1  FIFO full (qspi_clk domain); pushes while full are dropped by the FIFO.
- wr_addr  out  22  burst start address to controller.
- wr_avalid  out  1  address valid.
- wr_aready  in  1  address accepted.
- wr_data  out  16  write data, = {word[7:0],word[15:8]}.
- wr_dvalid  out  1  write data valid.
- wr_dready  in  1  controller accepts data.

Behaviour:
- Reset values: qspi_wr_busy=0, wr_addr=0, wr_avalid=0, wr_dvalid=0, wr_data=0, req sync flops=0, hold_valid=0, wr_cnt=0, state S_WR_IDLE.
- Request sync: two flops on qspi_wr_req in sdram_clk; req_pos = s0 & !s1.
  - On req_pos in S_WR_IDLE, latch wr_addr <= qspi_wr_addr[21:0].
  - req_pos outside S_WR_IDLE is ignored: no address latch, no state change.
- FSM states and transitions:
  - S_WR_IDLE -> S_WR_ADDR on req_pos.
  - S_WR_ADDR: wr_avalid=1; -> S_WR_DATA on wr_avalid & wr_aready.
  - S_WR_DATA: -> S_WR_IDLE on the data handshake when wr_cnt==WR_BL-1.
- FIFO read interface: asyn_fifo_top read data is registered, valid one sdram_clk after ren.
- Prefetch stage, one-entry hold register (hold_valid/hold_data):
  - ren = !rempty & (!hold_valid | (wr_dvalid & wr_dready)) & (state==S_WR_DATA) & (words popped this burst < WR_BL).
  - hold_valid is set the cycle after ren. It is cleared on a handshake with no concurrent refill.
- wr_dvalid = (state==S_WR_DATA) & hold_valid; wr_data is the byte-swapped hold_data.
- wr_dvalid never drops without a handshake once asserted. wr_data is stable while wr_dvalid & !wr_dready.
- Throughput: one word per cycle when FIFO non-empty and wr_dready=1. First wr_dvalid appears at earliest 2 cycles after entering S_WR_DATA.
- FIFO empty mid-burst: wr_dvalid deasserts only after the current word handshakes; the FSM waits in S_WR_DATA indefinitely.
- Pop limit: never pop more than WR_BL words per burst. Surplus FIFO words stay for the next request.
- wr_cnt: increments on each handshake and wraps to 0 at WR_BL-1.
- wr_aready asserted outside S_WR_ADDR: ignored. wr_dready outside S_WR_DATA: ignored.
- Reset mid-burst: the FSM returns to idle and FIFO pointers clear. The partial burst is abandoned; the controller sees wr_avalid/wr_dvalid drop asynchronously.
- Cross-domain rule: qspi_wr_busy is in the sdram_clk domain; the consumer synchronizes it.

Decomposition:
- Shared package: state encodings S_WR_IDLE=0, S_WR_ADDR=1, S_WR_DATA=2; SDRAM address width 22; data width 16.
- Sub-modules: instantiate the existing asyn_fifo_top (DATAWIDTH 16, ASIZE FIFO_ASIZE). No other sub-module; the prefetch stage is inline.

Test Plan:
- Basic burst: push 0x1234, 0xABCD at qspi_clk 40 MHz. Set addr 0x000100, raise req, wr_aready/wr_dready held high. Expect:
  - wr_addr=0x000100, one address handshake;
  - data 0x3412 then 0xCDAB;
  - busy drops 1 cycle after the 2nd handshake.
- Backpressure: as above with wr_dready toggling 1/0 every cycle. Expect wr_data held stable while stalled, exactly 2 handshakes, no dropped or duplicated word.
- Late data: raise req with FIFO empty; push 2 words 50 qspi cycles later. Expect the FSM to wait in S_WR_DATA, wr_dvalid=0 until data arrives, then the correct 2 words.
- Surplus words: push 5 words, issue 2 requests with addrs 0x10 and 0x20, WR_BL=2. Expect words 0,1 at 0x10 and words 2,3 at 0x20, with 1 word left in FIFO (rempty=0).
- Request while busy: second req edge during S_WR_DATA (addr 0x3F0000). Expect wr_addr unchanged and no extra burst.
- Reset: assert rst_n low mid-burst after 1 handshake. Expect all outputs 0, busy 0, FIFO empty. A fresh burst then completes normally.

Source files
------------

// File: rtl/fifo_wr_sdram_pkg.sv
// Shared widths, FSM encodings and the SDRAM byte-order helper for the QSPI-to-SDRAM write bridge.
package fifo_wr_sdram_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    localparam logic [1:0] S_WR_IDLE = 2'd0;
    localparam logic [1:0] S_WR_ADDR = 2'd1;
    localparam logic [1:0] S_WR_DATA = 2'd2;

    typedef logic [ADDR_W-1:0] sdram_addr_t;
    typedef logic [DATA_W-1:0] sdram_word_t;

    // The read path swaps bytes too, so a written word reads back unchanged.
    function automatic sdram_word_t swap_bytes(input sdram_word_t word);
        return {word[7:0], word[15:8]};
    endfunction

endpackage

// File: rtl/asyn_fifo_top.sv
// Dual-clock FIFO with Gray-coded pointers; read data is registered and valid one rclk after rinc.
module asyn_fifo_top #(
    parameter int DATAWIDTH = 16,
    parameter int ASIZE     = 10
) (
    input  logic                 wclk,
    input  logic                 rclk,
    input  logic                 rst_n,
    input  logic                 winc,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic                 wfull,
    input  logic                 rinc,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rempty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic [ASIZE:0] wbin, wgray, wbin_nx, wgray_nx;
    logic [ASIZE:0] rbin, rgray, rbin_nx, rgray_nx;
    logic [ASIZE:0] wq1_rgray, wq2_rgray, rq1_wgray, rq2_wgray;
    logic           wfull_nx, rempty_nx, wr_ok, rd_ok;

    assign wr_ok    = winc & ~wfull;
    assign rd_ok    = rinc & ~rempty;
    assign wbin_nx  = wbin + {{ASIZE{1'b0}}, wr_ok};
    assign wgray_nx = (wbin_nx >> 1) ^ wbin_nx;
    assign rbin_nx  = rbin + {{ASIZE{1'b0}}, rd_ok};
    assign rgray_nx = (rbin_nx >> 1) ^ rbin_nx;

    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    assign wfull_nx  = wgray_nx == {~wq2_rgray[ASIZE:ASIZE-1], wq2_rgray[ASIZE-2:0]};
    assign rempty_nx = rgray_nx == rq2_wgray;

    always_ff @(posedge wclk) begin
        if (wr_ok) begin
            mem[wbin[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin      <= '0;
            wgray     <= '0;
            wfull     <= 1'b0;
            wq1_rgray <= '0;
            wq2_rgray <= '0;
        end else begin
            wbin      <= wbin_nx;
            wgray     <= wgray_nx;
            wfull     <= wfull_nx;
            wq1_rgray <= rgray;
            wq2_rgray <= wq1_rgray;
        end
    end

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rbin      <= '0;
            rgray     <= '0;
            rempty    <= 1'b1;
            rdata     <= '0;
            rq1_wgray <= '0;
            rq2_wgray <= '0;
        end else begin
            rbin      <= rbin_nx;
            rgray     <= rgray_nx;
            rempty    <= rempty_nx;
            rq1_wgray <= wgray;
            rq2_wgray <= rq1_wgray;
            if (rd_ok) begin
                rdata <= mem[rbin[ASIZE-1:0]];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_sdram.sv
// QSPI-to-SDRAM write bridge: a synchronized request launches one address handshake,
// then WR_BL byte-swapped words are drained from the async FIFO into the data handshake.
module fifo_wr_sdram
    import fifo_wr_sdram_pkg::*;
#(
    parameter logic [2:0] WR_BL      = 3'd2,
    parameter int         FIFO_ASIZE = 10
) (
    input  logic        sdram_clk,
    input  logic        rst_n,
    input  logic        qspi_clk,
    input  logic [23:0] qspi_wr_addr,
    input  logic        qspi_wr_req,
    output logic        qspi_wr_busy,
    input  logic        fifo_wen,
    input  logic [15:0] fifo_wdata,
    output logic        fifo_wfull,
    output logic [21:0] wr_addr,
    output logic        wr_avalid,
    input  logic        wr_aready,
    output logic [15:0] wr_data,
    output logic        wr_dvalid,
    input  logic        wr_dready
);

    logic [1:0]  state;
    logic        req_s0, req_s1, req_pos;
    logic        hold_valid;
    sdram_word_t hold_data;
    logic [2:0]  wr_cnt, pop_cnt;
    logic        rempty, ren, a_hs, d_hs, last_word;
    logic        unused_addr_hi;

    // The FIFO's registered read port doubles as the one-entry hold register.
    asyn_fifo_top #(
        .DATAWIDTH (DATA_W),
        .ASIZE     (FIFO_ASIZE)
    ) u_fifo (
        .wclk   (qspi_clk),
        .rclk   (sdram_clk),
        .rst_n  (rst_n),
        .winc   (fifo_wen),
        .wdata  (fifo_wdata),
        .wfull  (fifo_wfull),
        .rinc   (ren),
        .rdata  (hold_data),
        .rempty (rempty)
    );

    assign unused_addr_hi = ^qspi_wr_addr[23:22];

    assign req_pos      = req_s0 & ~req_s1;
    assign qspi_wr_busy = state != S_WR_IDLE;
    assign wr_avalid    = state == S_WR_ADDR;
    assign wr_dvalid    = (state == S_WR_DATA) & hold_valid;
    assign wr_data      = swap_bytes(hold_data);
    assign a_hs         = wr_avalid & wr_aready;
    assign d_hs         = wr_dvalid & wr_dready;
    assign last_word    = wr_cnt == (WR_BL - 3'd1);
    assign ren          = ~rempty & (~hold_valid | d_hs) & (state == S_WR_DATA) & (pop_cnt < WR_BL);

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s0 <= 1'b0;
            req_s1 <= 1'b0;
        end else begin
            req_s0 <= qspi_wr_req;
            req_s1 <= req_s0;
        end
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WR_IDLE;
            wr_addr    <= '0;
            wr_cnt     <= '0;
            pop_cnt    <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (ren) begin
                hold_valid <= 1'b1;
                pop_cnt    <= pop_cnt + 3'd1;
            end else if (d_hs) begin
                hold_valid <= 1'b0;
            end
            if (d_hs) begin
                wr_cnt <= last_word ? 3'd0 : wr_cnt + 3'd1;
            end
            case (state)
                S_WR_IDLE: begin
                    if (req_pos) begin
                        wr_addr <= qspi_wr_addr[ADDR_W-1:0];
                        state   <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    if (a_hs) begin
                        state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    // All WR_BL pops have been handshaken here, so the pop budget can reset.
                    if (d_hs && last_word) begin
                        state   <= S_WR_IDLE;
                        pop_cnt <= '0;
                    end
                end
                default: state <= S_WR_IDLE;
            endcase
        end
    end

endmodule
